// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS instruction fetch stage.
// Holds the PC and fetches one word at a time over a req/ready handshake.
// Presents the word downstream over a valid/accept handshake.
// Picks the next PC from PC+4, a branch target or a J-type jump target.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory side
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  // decode / datapath side
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired_count
);

  typedef enum logic {S_FETCH, S_VALID} state_e;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        imem_req_q;
  logic [31:0] retired_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] branch_target_d;
  logic [31:0] jump_target_d;
  logic [31:0] pc_d;
  logic        accepted_d;
  logic        fetched_d;

  // Sequential address arithmetic and redirect targets; all wrap mod 2^32.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    pc_plus4_d      = pc_q + 32'd4;
    branch_target_d = pc_plus4_d + {branch_offset[29:0], 2'b00};
    jump_target_d   = {pc_plus4_d[31:28], jump_index, 2'b00};
    pc_d            = pc_plus4_d;
    if (jump) begin
      pc_d = jump_target_d;
    end else if (branch_taken) begin
      pc_d = branch_target_d;
    end
  end

  // Handshake qualifiers: memory data counts only while a request is out,
  // and an accept counts only while a word is actually held.
  always_comb begin
    fetched_d  = (state_q == S_FETCH) && imem_req_q && imem_ready;
    accepted_d = (state_q == S_VALID) && instr_valid_q && instr_accept;
  end

  // Fetch FSM: one request in flight, redirects applied only at accept.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC_ALIGNED;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      retired_q     <= '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (!imem_req_q) begin
            // First cycle out of reset: raise the request.
            imem_req_q <= 1'b1;
          end else if (fetched_d) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= S_VALID;
          end
        end
        S_VALID: begin
          if (accepted_d) begin
            pc_q          <= pc_d;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            retired_q     <= retired_q + 32'd1;
            state_q       <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_req      = imem_req_q;
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign instr_valid   = instr_valid_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_plus4_d;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_count;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_retired = '0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    instr_accept  = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_index    = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},     imem_req,      32'd0);
    check({tag, "_valid"},   instr_valid,   32'd0);
    check({tag, "_pc"},      pc,            32'h0000_0000);
    check({tag, "_instr"},   instr,         32'd0);
    check({tag, "_retired"}, retired_count, 32'd0);
  endtask

  // Wait (bounded) for a request, optionally stall the memory, then return addr+0x1000.
  task automatic fetch(input logic [31:0] exp_addr, input int stall);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", imem_req, 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
    check("fetch_pc_plus4", pc_plus4, exp_addr + 32'd4);
    for (int i = 0; i < stall; i++) begin
      // Redirects and accept are meaningless without a held word.
      instr_accept = 1'b1;
      jump         = 1'b1;
      branch_taken = 1'b1;
      jump_index   = 26'h3AB_CDEF;
      tick();
      check("stall_req", imem_req, 32'd1);
      check("stall_addr", imem_addr, exp_addr);
      check("stall_valid", instr_valid, 32'd0);
    end
    clear_ctrl();
    imem_ready = 1'b1;
    imem_rdata = exp_addr + 32'h1000;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("got_valid", instr_valid, 32'd1);
    check("got_instr", instr, exp_addr + 32'h1000);
    check("got_req_low", imem_req, 32'd0);
  endtask

  // Optionally hold off the accept, then accept with the given redirect controls.
  task automatic accept(input logic [31:0] cur_pc, input int hold, input logic j,
                        input logic [25:0] idx, input logic br, input logic [31:0] off,
                        input logic [31:0] exp_next);
    for (int i = 0; i < hold; i++) begin
      imem_ready = 1'b1;
      tick();
      check("hold_valid", instr_valid, 32'd1);
      check("hold_instr", instr, cur_pc + 32'h1000);
      check("hold_pc", pc, cur_pc);
      check("hold_no_req", imem_req, 32'd0);
    end
    imem_ready    = 1'b0;
    instr_accept  = 1'b1;
    jump          = j;
    jump_index    = idx;
    branch_taken  = br;
    branch_offset = off;
    tick();
    clear_ctrl();
    exp_retired = exp_retired + 32'd1;
    check("acc_valid", instr_valid, 32'd0);
    check("acc_req", imem_req, 32'd1);
    check("acc_addr", imem_addr, exp_next);
    check("acc_retired", retired_count, exp_retired);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    clear_ctrl();
    repeat (3) tick();
    check_reset_state("reset");

    // First request appears one cycle after reset is released.
    rst_n = 1'b1;
    tick();
    check("first_req", imem_req, 32'd1);

    // Sequential fetch with zero-wait memory.
    fetch(32'h0, 0);
    accept(32'h0, 0, 1'b0, '0, 1'b0, '0, 32'h4);
    fetch(32'h4, 0);
    accept(32'h4, 0, 1'b0, '0, 1'b0, '0, 32'h8);
    fetch(32'h8, 0);
    accept(32'h8, 0, 1'b0, '0, 1'b0, '0, 32'hC);
    fetch(32'hC, 0);
    accept(32'hC, 0, 1'b0, '0, 1'b0, '0, 32'h10);
    check("retired_after_4", retired_count, 32'd4);

    // Memory stall then datapath backpressure; accept jumps to 0x100.
    fetch(32'h10, 3);
    accept(32'h10, 4, 1'b1, 26'h40, 1'b0, '0, 32'h100);

    // Branches: 0x104 - 8 = 0xFC, then 0x100 + 12 = 0x10C.
    fetch(32'h100, 0);
    accept(32'h100, 0, 1'b0, '0, 1'b1, 32'hFFFF_FFFE, 32'h0FC);
    fetch(32'h0FC, 0);
    accept(32'h0FC, 0, 1'b0, '0, 1'b1, 32'h0000_0003, 32'h10C);

    // Long branch into the 0x1xxx_xxxx region: 0x110 + 0x0FFF_FF30.
    fetch(32'h10C, 0);
    accept(32'h10C, 0, 1'b0, '0, 1'b1, 32'h03FF_FFCC, 32'h1000_0040);

    // Jump and branch together: jump wins ({1, 0x10, 00}), branch would give 0x1000_0058.
    fetch(32'h1000_0040, 0);
    accept(32'h1000_0040, 0, 1'b1, 26'h000_0010, 1'b1, 32'h0000_0005, 32'h1000_0040);

    // Branch to the top word: 0x1000_0044 + 0xEFFF_FFB8, then wrap to zero.
    fetch(32'h1000_0040, 0);
    accept(32'h1000_0040, 0, 1'b0, '0, 1'b1, 32'h3BFF_FFEE, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 0);
    accept(32'hFFFF_FFFC, 0, 1'b0, '0, 1'b0, '0, 32'h0000_0000);

    // Reset while holding a word.
    fetch(32'h0, 0);
    rst_n        = 1'b0;
    instr_accept = 1'b1;
    tick();
    clear_ctrl();
    exp_retired = '0;
    check_reset_state("rst_valid");
    rst_n = 1'b1;
    tick();
    check("rst_valid_req", imem_req, 32'd1);

    // Reset while waiting on memory, with ready arriving at and after the reset.
    tick();
    check("wait_req", imem_req, 32'd1);
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    check_reset_state("rst_fetch");
    rst_n = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("late_ready_valid", instr_valid, 32'd0);
    check("late_ready_instr", instr, 32'd0);
    check("late_ready_req", imem_req, 32'd1);

    // Normal operation resumes from RESET_PC.
    fetch(32'h0, 0);
    accept(32'h0, 0, 1'b0, '0, 1'b0, '0, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
